// File: rtl/clkgen_pkg.sv
// Shared types and helpers for the multi-channel clock divider.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package clkgen_pkg;

    typedef enum logic [2:0] {
        ST_RESET,
        ST_APPLY,
        ST_ALIGN,
        ST_LOCKING,
        ST_LOCKED
    } clkgen_state_t;

    // Saturate v into [lo, hi]; callers guarantee lo <= hi.
    function automatic logic [31:0] clamp(input logic [31:0] v,
                                          input logic [31:0] lo,
                                          input logic [31:0] hi);
        if (v < lo) begin
            return lo;
        end else if (v > hi) begin
            return hi;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: wrapping counter plus registered clock / enable outputs.
// Latency: outputs are registered one refclk cycle after the counter value.
// Backpressure: none; runs every cycle, load realigns the counter.
module clkdiv_channel #(
    parameter int DIV_W = 16
) (
    input  logic             refclk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [DIV_W-1:0] div_eff,
    input  logic [DIV_W-1:0] hi_eff,
    input  logic [DIV_W-1:0] phase_eff,
    output logic             outclk,
    output logic             outclk_en
);

    logic [DIV_W-1:0] cnt;
    logic             running;

    // Ratios 0 and 1 need no counting; the counter parks at zero for them.
    assign running = (div_eff >= DIV_W'(2));

    // Counter: load the start phase on realign, otherwise wrap at div-1.
    // The >= compare keeps a stale count from a larger old ratio in range.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!running) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= phase_eff;
        end else if (cnt >= div_eff - DIV_W'(1)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + DIV_W'(1);
        end
    end

    // Output registers decoded from the current count.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            outclk    <= 1'b0;
            outclk_en <= 1'b0;
        end else if (div_eff == '0) begin
            outclk    <= 1'b0;
            outclk_en <= 1'b0;
        end else if (div_eff == DIV_W'(1)) begin
            outclk    <= 1'b1;
            outclk_en <= 1'b1;
        end else begin
            outclk    <= (cnt < hi_eff);
            outclk_en <= (cnt == '0);
        end
    end

endmodule

// File: rtl/multi_clkdiv_gen.sv
// Multi-channel programmable clock divider / clock-enable generator with lock flag.
// Latency: write accepted at edge T -> channels realign at T+1, locked LOCK_CYCLES edges later.
// Backpressure: cfg_ready low while in reset and for the one APPLY cycle after each write.
module multi_clkdiv_gen
    import clkgen_pkg::*;
#(
    parameter  int NUM_CLOCKS  = 4,
    parameter  int DIV_W       = 16,
    parameter  int DEFAULT_DIV = 2,
    parameter  int LOCK_CYCLES = 16,
    localparam int CHAN_W      = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1
) (
    input  logic                  refclk,
    input  logic                  rst_n,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [CHAN_W-1:0]     cfg_chan,
    input  logic [DIV_W-1:0]      cfg_div,
    input  logic [DIV_W-1:0]      cfg_hi,
    input  logic [DIV_W-1:0]      cfg_phase,
    output logic [NUM_CLOCKS-1:0] outclk,
    output logic [NUM_CLOCKS-1:0] outclk_en,
    output logic                  locked
);

    localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);

    clkgen_state_t    state;
    logic [LOCK_W-1:0] lock_cnt;
    logic             wr_acc;
    logic             load;

    logic [DIV_W-1:0] div_sh   [NUM_CLOCKS];
    logic [DIV_W-1:0] hi_sh    [NUM_CLOCKS];
    logic [DIV_W-1:0] phase_sh [NUM_CLOCKS];

    assign cfg_ready = (state == ST_ALIGN) || (state == ST_LOCKING) || (state == ST_LOCKED);
    assign wr_acc    = cfg_valid && cfg_ready;
    // Counters load on the edge that enters ALIGN.
    assign load      = (state == ST_RESET) || (state == ST_APPLY);

    // Control FSM; a write always wins and forces a full realign.
    // The ALIGN cycle counts as the first lock cycle, so locked rises LOCK_CYCLES edges after ALIGN.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_RESET;
            lock_cnt <= '0;
            locked   <= 1'b0;
        end else if (wr_acc) begin
            state    <= ST_APPLY;
            lock_cnt <= '0;
            locked   <= 1'b0;
        end else begin
            case (state)
                ST_RESET, ST_APPLY: begin
                    state    <= ST_ALIGN;
                    lock_cnt <= '0;
                end
                ST_ALIGN, ST_LOCKING: begin
                    if (lock_cnt == LOCK_W'(LOCK_CYCLES - 1)) begin
                        state  <= ST_LOCKED;
                        locked <= 1'b1;
                    end else begin
                        state    <= ST_LOCKING;
                        lock_cnt <= lock_cnt + LOCK_W'(1);
                    end
                end
                ST_LOCKED: begin
                    state <= ST_LOCKED;
                end
                default: begin
                    state  <= ST_RESET;
                    locked <= 1'b0;
                end
            endcase
        end
    end

    // Shadow registers; writes to a channel index beyond NUM_CLOCKS match nothing.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CLOCKS; i++) begin
                div_sh[i]   <= DIV_W'(DEFAULT_DIV);
                hi_sh[i]    <= DIV_W'(DEFAULT_DIV / 2);
                phase_sh[i] <= '0;
            end
        end else if (wr_acc) begin
            for (int i = 0; i < NUM_CLOCKS; i++) begin
                if (32'(cfg_chan) == i) begin
                    div_sh[i]   <= cfg_div;
                    hi_sh[i]    <= cfg_hi;
                    phase_sh[i] <= cfg_phase;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CLOCKS; g++) begin : g_chan
        logic [DIV_W-1:0] div_eff;
        logic [DIV_W-1:0] hi_eff;
        logic [DIV_W-1:0] phase_eff;

        // Effective values; channels stay quiet (ratio 0) until the FSM leaves RESET.
        always_comb begin
            div_eff   = (state == ST_RESET) ? '0 : div_sh[g];
            hi_eff    = '0;
            phase_eff = '0;
            if (div_sh[g] >= DIV_W'(2)) begin
                hi_eff    = DIV_W'(clamp(32'(hi_sh[g]), 32'd1, 32'(div_sh[g]) - 32'd1));
                phase_eff = DIV_W'(clamp(32'(phase_sh[g]), 32'd0, 32'(div_sh[g]) - 32'd1));
            end
        end

        clkdiv_channel #(
            .DIV_W (DIV_W)
        ) u_chan (
            .refclk    (refclk),
            .rst_n     (rst_n),
            .load      (load),
            .div_eff   (div_eff),
            .hi_eff    (hi_eff),
            .phase_eff (phase_eff),
            .outclk    (outclk[g]),
            .outclk_en (outclk_en[g])
        );
    end

endmodule

// File: tb/tb_multi_clkdiv_gen.sv
// Directed bench for multi_clkdiv_gen: config vector table plus reset / relock sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_multi_clkdiv_gen;

    localparam int NCLK = 3;
    localparam int DW   = 16;
    localparam int LC   = 8;
    localparam int PN   = 10;

    logic            refclk;
    logic            rst_n;
    logic            cfg_valid;
    logic            cfg_ready;
    logic [1:0]      cfg_chan;
    logic [DW-1:0]   cfg_div;
    logic [DW-1:0]   cfg_hi;
    logic [DW-1:0]   cfg_phase;
    logic [NCLK-1:0] outclk;
    logic [NCLK-1:0] outclk_en;
    logic            locked;

    int n_vec = 0;
    int n_err = 0;

    multi_clkdiv_gen #(
        .NUM_CLOCKS  (NCLK),
        .DIV_W       (DW),
        .DEFAULT_DIV (2),
        .LOCK_CYCLES (LC)
    ) dut (
        .refclk    (refclk),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_chan  (cfg_chan),
        .cfg_div   (cfg_div),
        .cfg_hi    (cfg_hi),
        .cfg_phase (cfg_phase),
        .outclk    (outclk),
        .outclk_en (outclk_en),
        .locked    (locked)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    typedef struct {
        logic [1:0]    chan;
        logic [DW-1:0] div;
        logic [DW-1:0] hi;
        logic [DW-1:0] phase;
        int            obs;
        logic [PN-1:0] exp_clk;
        logic [PN-1:0] exp_en;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    // Called at a negedge; the write is accepted at the next posedge, returns one negedge later.
    task automatic do_write(input logic [1:0] ch, input logic [DW-1:0] dv,
                            input logic [DW-1:0] hv, input logic [DW-1:0] pv);
        check("ready_before_write", 0, 32'(cfg_ready), 32'd1);
        cfg_chan  = ch;
        cfg_div   = dv;
        cfg_hi    = hv;
        cfg_phase = pv;
        cfg_valid = 1'b1;
        @(negedge refclk);
        cfg_valid = 1'b0;
    endtask

    // Called one negedge after the accept edge: APPLY cycle, ALIGN cycle, then PN output cycles.
    task automatic check_pattern(input int obs, input logic [PN-1:0] ec, input logic [PN-1:0] ee);
        check("apply_ready", obs, 32'(cfg_ready), 32'd0);
        check("apply_locked", obs, 32'(locked), 32'd0);
        @(negedge refclk);
        check("align_ready", obs, 32'(cfg_ready), 32'd1);
        for (int j = 0; j < PN; j++) begin
            @(negedge refclk);
            check("pat_outclk", j, 32'(outclk[obs]), 32'(ec[PN-1-j]));
            check("pat_outclk_en", j, 32'(outclk_en[obs]), 32'(ee[PN-1-j]));
            check("pat_locked", j, 32'(locked), (j >= LC - 1) ? 32'd1 : 32'd0);
        end
    endtask

    // Called at the negedge where rst_n was released; defaults toggle 1,0,1,0 on every channel.
    task automatic check_poweron();
        logic [NCLK-1:0] e;
        for (int k = 1; k <= LC + 1; k++) begin
            @(negedge refclk);
            e = (k >= 2 && (k % 2) == 0) ? '1 : '0;
            check("po_ready", k, 32'(cfg_ready), 32'd1);
            check("po_locked", k, 32'(locked), (k >= LC + 1) ? 32'd1 : 32'd0);
            check("po_outclk", k, 32'(outclk), 32'(e));
            check("po_outclk_en", k, 32'(outclk_en), 32'(e));
        end
    endtask

    initial begin
        vecs[0] = '{2'd0, 16'd5, 16'd2, 16'd0, 0, 10'b1100011000, 10'b1000010000};
        vecs[1] = '{2'd0, 16'd4, 16'd2, 16'd0, 1, 10'b1010101010, 10'b1010101010};
        vecs[2] = '{2'd1, 16'd4, 16'd2, 16'd1, 1, 10'b1001100110, 10'b0001000100};
        vecs[3] = '{2'd3, 16'd9, 16'd1, 16'd0, 0, 10'b1100110011, 10'b1000100010};
        vecs[4] = '{2'd2, 16'd0, 16'd5, 16'd0, 2, 10'b0000000000, 10'b0000000000};
        vecs[5] = '{2'd2, 16'd1, 16'd0, 16'd7, 2, 10'b1111111111, 10'b1111111111};
        vecs[6] = '{2'd2, 16'd3, 16'd0, 16'd0, 2, 10'b1001001001, 10'b1001001001};
        vecs[7] = '{2'd2, 16'd3, 16'd2, 16'd9, 2, 10'b0110110110, 10'b0100100100};
        vecs[8] = '{2'd2, 16'd3, 16'd7, 16'd1, 2, 10'b1011011011, 10'b0010010010};

        cfg_valid = 1'b0;
        cfg_chan  = '0;
        cfg_div   = '0;
        cfg_hi    = '0;
        cfg_phase = '0;
        rst_n     = 1'b1;
        #1 rst_n  = 1'b0;

        // Reset state.
        @(negedge refclk);
        @(negedge refclk);
        check("rst_outclk", 0, 32'(outclk), 32'd0);
        check("rst_outclk_en", 0, 32'(outclk_en), 32'd0);
        check("rst_locked", 0, 32'(locked), 32'd0);
        check("rst_ready", 0, 32'(cfg_ready), 32'd0);

        rst_n = 1'b1;
        check_poweron();

        // Configuration table.
        for (int v = 0; v < 9; v++) begin
            do_write(vecs[v].chan, vecs[v].div, vecs[v].hi, vecs[v].phase);
            check_pattern(vecs[v].obs, vecs[v].exp_clk, vecs[v].exp_en);
        end

        // cfg_valid held across APPLY: second write taken when ready returns in ALIGN.
        check("held_ready_before", 0, 32'(cfg_ready), 32'd1);
        cfg_chan  = 2'd1; cfg_div = 16'd2; cfg_hi = 16'd1; cfg_phase = 16'd0;
        cfg_valid = 1'b1;
        @(negedge refclk);
        check("held_apply_ready", 0, 32'(cfg_ready), 32'd0);
        cfg_chan  = 2'd2; cfg_div = 16'd5; cfg_hi = 16'd3; cfg_phase = 16'd4;
        @(negedge refclk);
        check("held_align_ready", 0, 32'(cfg_ready), 32'd1);
        @(negedge refclk);
        cfg_valid = 1'b0;
        check_pattern(2, 10'b0111001110, 10'b0100001000);

        // Second write during LOCKING restarts the lock count.
        do_write(2'd0, 16'd4, 16'd2, 16'd0);
        for (int s = 1; s <= 4; s++) begin
            check("lk1_locked", s, 32'(locked), 32'd0);
            @(negedge refclk);
        end
        do_write(2'd1, 16'd4, 16'd2, 16'd1);
        for (int k = 1; k <= LC + 2; k++) begin
            if (k > 1) @(negedge refclk);
            check("lk2_locked", k, 32'(locked), (k >= LC + 2) ? 32'd1 : 32'd0);
        end

        // Asynchronous reset mid-run with div=5 on channel 0.
        @(negedge refclk);
        do_write(2'd0, 16'd5, 16'd2, 16'd0);
        check_pattern(0, 10'b1100011000, 10'b1000010000);
        #2 rst_n = 1'b0;
        #1;
        check("arst_outclk", 0, 32'(outclk), 32'd0);
        check("arst_outclk_en", 0, 32'(outclk_en), 32'd0);
        check("arst_locked", 0, 32'(locked), 32'd0);
        check("arst_ready", 0, 32'(cfg_ready), 32'd0);
        @(negedge refclk);
        @(negedge refclk);
        rst_n = 1'b1;
        check_poweron();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
